compute_core_mt: RTL

- Parametrised multi-thread compute core with round-robin thread interleaving, per-thread PC, register file and compare flags.
- Instruction and data memories are external, reached through valid/ready request ports, so the core tolerates wait states.
- Sits between the kernel launcher (start, halt) and the shared memory arbiter.
- Adds to the current core: JEQ, base+offset loads/stores, illegal-opcode flag and a debug register read port.

---
 rtl/compute_core_mt.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/compute_core_mt.sv
// compute_core_mt: multi-thread compute core with round-robin interleaving.
// Each hardware thread has its own PC, register file and lt/eq flags. A
// single shared pipeline walks SCHED -> FETCH -> EXEC -> (MEM) for one
// thread at a time. Instruction and data memories sit behind valid/ready
// handshakes, so any number of wait states is tolerated.
//
// Ports:
//   clk, reset                clock (rising edge), async active-low reset
//   start                     one-cycle launch pulse, honoured in IDLE only
//   imem_req/addr/valid/data  instruction fetch handshake
//   dmem_req/we/addr/wdata    data request (held until dmem_ready)
//   dmem_ready/rdata          accept strobe; load data valid with it
//   busy, halt                running / all threads finished
//   thread_active             per-thread live mask
//   illegal_op                sticky undefined-opcode flag
//   dbg_thread/dbg_reg/data   combinational register file read port
module compute_core_mt #(
    parameter int  NUM_THREADS     = 4,
    parameter int  REG_COUNT       = 16,
    parameter int  DATA_WIDTH      = 16,
    parameter int  ADDR_WIDTH      = 8,
    parameter int  DMEM_ADDR_WIDTH = 8,
    parameter int  INSTR_WIDTH     = 20,
    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       imem_req,
    output logic [ADDR_WIDTH-1:0]      imem_addr,
    input  logic                       imem_valid,
    input  logic [INSTR_WIDTH-1:0]     imem_data,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0]      dmem_wdata,
    input  logic                       dmem_ready,
    input  logic [DATA_WIDTH-1:0]      dmem_rdata,
    output logic                       busy,
    output logic                       halt,
    output logic [NUM_THREADS-1:0]     thread_active,
    output logic                       illegal_op,
    input  logic [TW-1:0]              dbg_thread,
    input  logic [3:0]                 dbg_reg,
    output logic [DATA_WIDTH-1:0]      dbg_data
);

    typedef enum logic [2:0] {IDLE, SCHED, FETCH, EXEC, MEM, DONE} state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_MUL = 4'h3,
        OP_CMP = 4'h4, OP_JMP = 4'h5, OP_JLT = 4'h6, OP_JEQ = 4'h7,
        OP_LDR = 4'h8, OP_STR = 4'h9, OP_HALT = 4'hF
    } opcode_t;

    state_t                      state_q, state_d;
    logic [TW-1:0]               cur_q, rr_q, pick, cand;
    logic [ADDR_WIDTH-1:0]       pc_q [NUM_THREADS];
    logic [DATA_WIDTH-1:0]       regs_q [NUM_THREADS][REG_COUNT];
    logic [NUM_THREADS-1:0]      active_q, lt_q, eq_q, halt_mask;
    logic [INSTR_WIDTH-1:0]      instr_q;
    logic                        illegal_q;
    logic [DMEM_ADDR_WIDTH-1:0]  maddr_q;
    logic                        mwe_q;
    logic [DATA_WIDTH-1:0]       mwdata_q;

    // Instruction fields of the latched instruction.
    logic [3:0]            op, rd_idx, rs_idx;
    logic [DATA_WIDTH-1:0] imm_x, rd_val, rs_val, wr_val, ea;
    logic [ADDR_WIDTH-1:0] pc_cur, pc_nxt;
    logic                  rd_ok, wr_en, set_flags, do_halt, is_mem, is_illegal;

    assign op     = instr_q[19:16];
    assign rd_idx = instr_q[15:12];
    assign rs_idx = instr_q[11:8];
    assign imm_x  = DATA_WIDTH'(instr_q[7:0]);
    assign rd_ok  = int'(rd_idx) < REG_COUNT;
    assign rd_val = rd_ok ? regs_q[cur_q][rd_idx] : '0;
    assign rs_val = (int'(rs_idx) < REG_COUNT) ? regs_q[cur_q][rs_idx] : '0;
    assign pc_cur = pc_q[cur_q];
    assign ea     = rs_val + imm_x;

    // Round-robin pick: scanning from the far end down means the last
    // match, i.e. the nearest active thread at or after rr_q, wins.
    always_comb begin
        pick = rr_q;
        cand = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            cand = TW'((int'(rr_q) + i) % NUM_THREADS);
            if (active_q[cand]) pick = cand;
        end
    end

    // Execute-stage decode and ALU.
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        wr_en      = 1'b0;
        wr_val     = rd_val;
        pc_nxt     = pc_cur + ADDR_WIDTH'(1);
        set_flags  = 1'b0;
        do_halt    = 1'b0;
        is_mem     = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_NOP: ;
            OP_ADD: begin wr_en = 1'b1; wr_val = rd_val + rs_val + imm_x; end
            OP_SUB: begin wr_en = 1'b1; wr_val = rd_val - rs_val - imm_x; end
            OP_MUL: begin wr_en = 1'b1; wr_val = rd_val * rs_val; end
            OP_CMP: set_flags = 1'b1;
            OP_JMP: pc_nxt = ADDR_WIDTH'(instr_q[7:0]);
            OP_JLT: if (lt_q[cur_q]) pc_nxt = ADDR_WIDTH'(instr_q[7:0]);
            OP_JEQ: if (eq_q[cur_q]) pc_nxt = ADDR_WIDTH'(instr_q[7:0]);
            OP_LDR, OP_STR: is_mem = 1'b1;
            OP_HALT: begin do_halt = 1'b1; pc_nxt = pc_cur; end
            default: is_illegal = 1'b1;
        endcase
    end

    assign halt_mask = do_halt ? (NUM_THREADS'(1) << cur_q) : '0;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = SCHED;
            SCHED: state_d = FETCH;
            FETCH: if (imem_valid) state_d = EXEC;
            EXEC: begin
                if (is_mem)                             state_d = MEM;
                else if ((active_q & ~halt_mask) == '0) state_d = DONE;
                else                                    state_d = SCHED;
            end
            MEM:   if (dmem_ready) state_d = (active_q == '0) ? DONE : SCHED;
            DONE:  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs. Address/data buses read zero outside their phase.
    always_comb begin
        imem_req   = (state_q == FETCH);
        imem_addr  = (state_q == FETCH) ? pc_cur : '0;
        dmem_req   = (state_q == MEM);
        dmem_we    = (state_q == MEM) && mwe_q;
        dmem_addr  = (state_q == MEM) ? maddr_q : '0;
        dmem_wdata = (state_q == MEM) ? mwdata_q : '0;
        busy       = (state_q != IDLE) && (state_q != DONE);
        halt       = (state_q == DONE);
    end

    // Architectural state.
    // NOTE: the register file is reset explicitly because the top register of
    // every thread must come up holding the thread id; a plain RAM could not.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_q[t] <= '0;
                for (int r = 0; r < REG_COUNT; r++)
                    regs_q[t][r] <= (r == REG_COUNT - 1) ? DATA_WIDTH'(t) : '0;
            end
            active_q  <= '1;
            lt_q      <= '0;
            eq_q      <= '0;
            rr_q      <= '0;
            cur_q     <= '0;
            instr_q   <= '0;
            illegal_q <= 1'b0;
            maddr_q   <= '0;
            mwe_q     <= 1'b0;
            mwdata_q  <= '0;
        end else begin
            case (state_q)
                SCHED: begin
                    cur_q <= pick;
                    rr_q  <= TW'((int'(pick) + 1) % NUM_THREADS);
                end
                FETCH: if (imem_valid) instr_q <= imem_data;
                EXEC: begin
                    if (wr_en && rd_ok) regs_q[cur_q][rd_idx] <= wr_val;
                    if (set_flags) begin
                        lt_q[cur_q] <= rd_val < rs_val;
                        eq_q[cur_q] <= rd_val == rs_val;
                    end
                    // Memory ops advance the PC only once the access completes.
                    if (!is_mem) pc_q[cur_q] <= pc_nxt;
                    if (do_halt) active_q[cur_q] <= 1'b0;
                    if (is_illegal) illegal_q <= 1'b1;
                    if (is_mem) begin
                        maddr_q  <= DMEM_ADDR_WIDTH'(ea);
                        mwe_q    <= (op == OP_STR);
                        mwdata_q <= rd_val;
                    end
                end
                MEM: if (dmem_ready) begin
                    if (!mwe_q && rd_ok) regs_q[cur_q][rd_idx] <= dmem_rdata;
                    pc_q[cur_q] <= pc_cur + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign thread_active = active_q;
    assign illegal_op    = illegal_q;

    always_comb begin
        dbg_data = '0;
        if (int'(dbg_reg) < REG_COUNT && int'(dbg_thread) < NUM_THREADS)
            dbg_data = regs_q[dbg_thread][dbg_reg];
    end

endmodule
